// File: rtl/sched_pkg.sv
// ---------------------------------------------------------------------------
// sched_pkg -- shared scheduler definitions for the issue_select slice.
//   RS_ENTRIES / LAT_W : reservation-station size and latency field width
//   rs_idx_t / lat_t   : entry index and latency types
//   issue_state_e      : issue controller states
//   norm_lat           : maps latency 0 onto 1
//   pick_lowest        : fixed-priority encoder, lowest set bit wins
// ---------------------------------------------------------------------------
package sched_pkg;

    localparam int RS_ENTRIES = 8;
    localparam int LAT_W      = 3;
    localparam int IDX_W      = $clog2(RS_ENTRIES);

    typedef logic [IDX_W-1:0] rs_idx_t;
    typedef logic [LAT_W-1:0] lat_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        BUSY  = 2'd2
    } issue_state_e;

    localparam lat_t LAT_ONE = {{(LAT_W-1){1'b0}}, 1'b1};

    // A dispatched latency of zero is meaningless; it is executed as one cycle.
    function automatic lat_t norm_lat(input lat_t lat);
        return (lat == '0) ? LAT_ONE : lat;
    endfunction

    // Scan from the top so the lowest set bit is the last one written.
    function automatic rs_idx_t pick_lowest(input logic [RS_ENTRIES-1:0] vec);
        rs_idx_t idx;
        idx = '0;
        for (int i = RS_ENTRIES - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = rs_idx_t'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/issue_select_age_matrix_select.sv
// ---------------------------------------------------------------------------
// age_matrix_select -- oldest-first pick over the reservation-station entries.
// Only instantiated when ISSUE_SELECT_AGE_EN is defined.
//   clk, rst        : clock, asynchronous active-high reset
//   i_alloc_valid   : dispatch writes entry i_alloc_entry this cycle
//   i_alloc_entry   : entry being written (becomes the youngest)
//   i_valid         : entries currently holding an op
//   i_cand          : requesting and valid entries
//   o_grant         : oldest candidate (0 when none)
// ---------------------------------------------------------------------------
module age_matrix_select
    import sched_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_alloc_valid,
    input  rs_idx_t               i_alloc_entry,
    input  logic [RS_ENTRIES-1:0] i_valid,
    input  logic [RS_ENTRIES-1:0] i_cand,
    output rs_idx_t               o_grant
);

    // r_older[i][j] == 1 means entry i is older than entry j.
    logic [RS_ENTRIES-1:0] r_older [RS_ENTRIES];
    logic [RS_ENTRIES-1:0] w_win;

    // Age matrix update: a new entry is younger than every valid entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < RS_ENTRIES; i++) begin
                r_older[i] <= '0;
            end
        end else if (i_alloc_valid) begin
            for (int i = 0; i < RS_ENTRIES; i++) begin
                if (rs_idx_t'(i) == i_alloc_entry) begin
                    r_older[i] <= '0;
                end else begin
                    r_older[i][i_alloc_entry] <= i_valid[i];
                end
            end
        end
    end

    // A candidate wins when no other candidate is older than it.
    always_comb begin
        w_win = '0;
        for (int i = 0; i < RS_ENTRIES; i++) begin
            w_win[i] = i_cand[i];
            for (int j = 0; j < RS_ENTRIES; j++) begin
                if (i_cand[j] && r_older[j][i]) begin
                    w_win[i] = 1'b0;
                end else begin
                    w_win[i] = w_win[i];
                end
            end
        end
    end

    assign o_grant = pick_lowest(w_win);

endmodule

// File: rtl/issue_select.sv
// ---------------------------------------------------------------------------
// issue_select -- per-FU issue controller between wakeup and one FU pipe.
// Picks one ready entry per cycle, hands it to the FU with valid/ready,
// tracks non-pipelined multi-cycle occupancy and pulses completion.
// Build option: ISSUE_SELECT_AGE_EN selects oldest-first instead of the
// default lowest-index-first selection.
//   clk, rst               : clock, asynchronous active-high reset
//   alloc_valid/entry/lat  : dispatch writes an entry and its FU latency
//   reqs                   : wakeup request vector
//   grant, grant_valid     : combinational grant returned to wakeup
//   issue_valid/entry      : registered op presented to the FU
//   fu_ready               : FU accepts the presented op
//   done_valid/entry       : registered one-cycle completion pulse
// ---------------------------------------------------------------------------
module issue_select
    import sched_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  alloc_valid,
    input  rs_idx_t               alloc_entry,
    input  lat_t                  alloc_lat,
    input  logic [RS_ENTRIES-1:0] reqs,
    output rs_idx_t               grant,
    output logic                  grant_valid,
    output logic                  issue_valid,
    output rs_idx_t               issue_entry,
    input  logic                  fu_ready,
    output logic                  done_valid,
    output rs_idx_t               done_entry
);

    issue_state_e          r_state;
    issue_state_e          w_state_nxt;
    lat_t                  r_cnt;
    lat_t                  w_cnt_nxt;
    logic [RS_ENTRIES-1:0] r_valid;
    lat_t                  r_lat [RS_ENTRIES];
    logic                  r_issue_valid;
    rs_idx_t               r_issue_entry;
    logic                  r_done_valid;
    rs_idx_t               r_done_entry;

    logic [RS_ENTRIES-1:0] w_cand;
    rs_idx_t               w_pick;
    lat_t                  w_cur_lat;
    logic                  w_gen;
    logic                  w_fin;
    logic                  w_grant_valid;

    // Requests from entries not holding an op are ignored.
    assign w_cand    = reqs & r_valid;
    assign w_cur_lat = r_lat[r_issue_entry];

`ifdef ISSUE_SELECT_AGE_EN
    age_matrix_select u_age (
        .clk           (clk),
        .rst           (rst),
        .i_alloc_valid (alloc_valid),
        .i_alloc_entry (alloc_entry),
        .i_valid       (r_valid),
        .i_cand        (w_cand),
        .o_grant       (w_pick)
    );
`else
    assign w_pick = pick_lowest(w_cand);
`endif

    // Entry table: alloc sets, completion clears (never the same entry).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= '0;
            for (int i = 0; i < RS_ENTRIES; i++) begin
                r_lat[i] <= '0;
            end
        end else begin
            if (w_fin) begin
                r_valid[r_issue_entry] <= 1'b0;
            end
            if (alloc_valid) begin
                r_valid[alloc_entry] <= 1'b1;
                r_lat[alloc_entry]   <= norm_lat(alloc_lat);
            end
        end
    end

    // State register plus the registered FU-side outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= IDLE;
            r_cnt         <= '0;
            r_issue_valid <= 1'b0;
            r_issue_entry <= '0;
            r_done_valid  <= 1'b0;
            r_done_entry  <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_cnt         <= w_cnt_nxt;
            r_issue_valid <= (w_state_nxt == ISSUE);
            r_issue_entry <= w_grant_valid ? w_pick : r_issue_entry;
            r_done_valid  <= w_fin;
            r_done_entry  <= w_fin ? r_issue_entry : r_done_entry;
        end
    end

    // Grant enable / completion decode; the FU frees up in the op's last cycle.
    always_comb begin
        w_gen = 1'b0;
        w_fin = 1'b0;
        case (r_state)
            IDLE: begin
                w_gen = 1'b1;
            end
            ISSUE: begin
                if (fu_ready && (w_cur_lat == LAT_ONE)) begin
                    w_gen = 1'b1;
                    w_fin = 1'b1;
                end else begin
                    w_gen = 1'b0;
                end
            end
            BUSY: begin
                if (r_cnt == LAT_ONE) begin
                    w_gen = 1'b1;
                    w_fin = 1'b1;
                end else begin
                    w_gen = 1'b0;
                end
            end
            default: begin
                w_gen = 1'b0;
                w_fin = 1'b0;
            end
        endcase
        w_grant_valid = w_gen && (|w_cand);
    end

    // Next-state and occupancy counter.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            IDLE: begin
                w_state_nxt = w_grant_valid ? ISSUE : IDLE;
            end
            ISSUE: begin
                if (!fu_ready) begin
                    w_state_nxt = ISSUE;
                end else if (w_cur_lat == LAT_ONE) begin
                    w_state_nxt = w_grant_valid ? ISSUE : IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_state_nxt = BUSY;
                    w_cnt_nxt   = w_cur_lat - LAT_ONE;
                end
            end
            BUSY: begin
                if (r_cnt == LAT_ONE) begin
                    w_state_nxt = w_grant_valid ? ISSUE : IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt   = r_cnt - LAT_ONE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign grant_valid = w_grant_valid;
    assign grant       = w_grant_valid ? w_pick : '0;
    assign issue_valid = r_issue_valid;
    assign issue_entry = r_issue_entry;
    assign done_valid  = r_done_valid;
    assign done_entry  = r_done_entry;

endmodule

// File: doc/issue_select.md
# issue_select

Per-functional-unit issue controller that sits between the scheduler's wakeup logic and one FU pipe.
- Picks one ready reservation-station entry per cycle from the wakeup request vector.
- Returns the grant to wakeup in the same cycle and presents the entry to the FU with a valid/ready handshake.
- Tracks non-pipelined multi-cycle FU occupancy.
- Emits a completion pulse that drives the wakeup retire port.

## Interface
Parameters:
- RS_ENTRIES, 8, reservation-station entries served by this FU pipe.
- LAT_W, 3, width of per-entry latency field; supported latencies 1..2^LAT_W-1.

Ports:
- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-high
- alloc_valid  input  1  dispatch writes an entry this cycle
- alloc_entry  input  $clog2(RS_ENTRIES)  entry being written (wakeup free entry)
- alloc_lat  input  LAT_W  FU latency of the dispatched op; 0 treated as 1
- reqs  input  RS_ENTRIES  request vector from wakeup
- grant  output  $clog2(RS_ENTRIES)  selected entry, combinational
- grant_valid  output  1  grant is valid, combinational
- issue_valid  output  1  op presented to FU, registered
- issue_entry  output  $clog2(RS_ENTRIES)  entry presented to FU
- fu_ready  input  1  FU accepts issue_valid this cycle
- done_valid  output  1  op finished; one-cycle pulse, registered
- done_entry  output  $clog2(RS_ENTRIES)  finished entry (to wakeup retire_entry)

## Operation
Entry tracking:
- alloc_valid sets valid[alloc_entry] and stores lat[alloc_entry] = max(alloc_lat, 1).
- Done of entry e clears valid[e].

State machine (IDLE, ISSUE, BUSY):
- IDLE: no op held.
- ISSUE: issue_valid=1, holding entry e until fu_ready.
- BUSY: FU occupied; down-counter cnt of remaining cycles.

Grant enable (gen) is asserted when any of the following holds:
- state==IDLE.
- state==ISSUE && fu_ready && lat[e]==1.
- state==BUSY && cnt==1.

Grant:
- grant_valid = gen && |(reqs & valid).
- The winner is registered into issue_entry.
- The next state is ISSUE if a grant was made, otherwise as below.

Transitions:
- ISSUE && fu_ready && lat==1 → done next cycle; next state ISSUE if granted, else IDLE.
- ISSUE && fu_ready && lat>1 → BUSY, cnt=lat-1.
- ISSUE && !fu_ready → stay, entry and issue_valid held stable.
- BUSY && cnt>1 → cnt-1.
- BUSY && cnt==1 → done next cycle; next state ISSUE if granted, else IDLE.

Done behaviour:
- done_valid pulses exactly once per accepted op; done_entry = that entry.

Boundary conditions:
- reqs bits for invalid entries are ignored.
- alloc and done in the same cycle target different entries (wakeup guarantees this); both take effect.
- An alloc of entry k in the same cycle as a grant does not affect that grant.
- reqs==0 with gen high → grant_valid=0, grant=0.
- Reset mid-op: all state returns to IDLE and any in-flight op is dropped with no done pulse.

## Timing
Reset values:
- issue_valid=0, issue_entry=0, done_valid=0, done_entry=0.
- State IDLE, cnt=0, all valid=0.

Latency:
- Grant in cycle T → issue_valid in T+1.
- Op accepted in cycle A with latency L occupies A..A+L-1, with done_valid in A+L.
- The next grant can occur in A+L-1, so latency-1 ops issue back-to-back every cycle with fu_ready held high.

Combinational path:
- grant/grant_valid depend combinationally on reqs, state, cnt and fu_ready. Wakeup registers them.

## Configuration
- ISSUE_SELECT_AGE_EN defined:
  - Oldest-first selection via an RS_ENTRIES×RS_ENTRIES age matrix.
  - On alloc of k, row k is cleared and column k is set for every currently valid entry, so k becomes the youngest.
  - Winner: req i with no older requesting j.
- Not defined:
  - Age matrix omitted.
  - Fixed priority, lowest index wins.

## Structure
- Shared sched_pkg holds:
  - RS_ENTRIES and LAT_W.
  - typedefs rs_idx_t and lat_t.
  - enum issue_state_e {IDLE, ISSUE, BUSY}.
- One sub-module, age_matrix_select:
  - Holds the age matrix and the oldest-first pick.
  - Instantiated only under ISSUE_SELECT_AGE_EN.
  - Fixed-priority encoder inline otherwise.

## Test plan
- Reset mid-BUSY (lat 4 op, rst in 2nd cycle) → issue_valid=0, done_valid never pulses, next grant allowed immediately after reset release.
- Alloc entries 5,2,7 (lat 1), reqs=8'hA4, fu_ready=1.
  - With ISSUE_SELECT_AGE_EN: grant order 5,2,7 on consecutive cycles, one done per cycle.
  - Without it: order 2,5,7.
- Entry 3 lat 4, fu_ready=1 → accepted cycle A, grant_valid low A..A+2, new grant at A+3, done_valid/done_entry=3 at A+4.
- fu_ready low 3 cycles while issue_valid=1 → issue_entry stable, grant_valid=0 throughout, accept on 4th cycle.
- alloc_lat=0 on entry 1 → behaves as latency 1 (done one cycle after accept).
